// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types for the integer register file write side.
// The pipeline writeback stage, the MUL/DIV unit and the write arbiter
// all use these definitions.
package reg_wb_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // A single register write: destination index and the value to store.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry circular FIFO of wb_req_t that buffers MUL/DIV results.
// DEPTH must be a power of two, so the pointers wrap on plain overflow.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset (RESET empties the FIFO)
//   push_i       write wdata_i at the tail (the caller never pushes when full)
//   pop_i        drop the head entry (the caller never pops when empty)
//   wdata_i      entry to push
//   rdata_o      current head entry (valid when count_o != 0)
//   count_o      number of stored entries
module wb_fifo
   import reg_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  wb_req_t                      wdata_i,
   output wb_req_t                      rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_req_t            mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q;
   logic [PTR_W-1:0]   tail_q;
   logic [CNT_W-1:0]   count_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[tail_q] <= wdata_i;
            tail_q        <= tail_q + PTR_W'(1);
         end
         if (pop_i) begin
            head_q <= head_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-side controller for the 32x32 integer register file.
// Merges pipeline writeback results (always take priority) with buffered
// MUL/DIV results onto the single register file write port, and keeps a
// busy scoreboard of registers that still have a MUL/DIV result pending.
// Ports:
//   CLK, RESET                 clock and synchronous active-high reset
//   ALU_VALID/ADDR/DATA        pipeline writeback result (never stalled)
//   MD_VALID/READY/ADDR/DATA   MUL/DIV result handshake into the FIFO
//   ISSUE_MD, ISSUE_ADDR       MUL/DIV issue, marks its destination busy
//   CHK_ADDR1/2, BUSY1/2       decode source checks against pending writes
//   REG_WRITE/ADDR/DATA        registered register file write port
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int DATA_W   = reg_wb_arbiter_pkg::DATA_W,
   parameter int ADDR_W   = reg_wb_arbiter_pkg::ADDR_W,
   parameter int MD_DEPTH = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ALU_VALID,
   input  logic [ADDR_W-1:0] ALU_ADDR,
   input  logic [DATA_W-1:0] ALU_DATA,
   input  logic              MD_VALID,
   output logic              MD_READY,
   input  logic [ADDR_W-1:0] MD_ADDR,
   input  logic [DATA_W-1:0] MD_DATA,
   input  logic              ISSUE_MD,
   input  logic [ADDR_W-1:0] ISSUE_ADDR,
   input  logic [ADDR_W-1:0] CHK_ADDR1,
   input  logic [ADDR_W-1:0] CHK_ADDR2,
   output logic              BUSY1,
   output logic              BUSY2,
   output logic              REG_WRITE,
   output logic [ADDR_W-1:0] REG_ADDR,
   output logic [DATA_W-1:0] REG_DATA
);

   localparam int CNT_W = $clog2(MD_DEPTH+1);
   localparam int NREGS = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MD_DEPTH);

   wb_req_t            md_req;
   wb_req_t            md_head;
   logic [CNT_W-1:0]   md_count;
   logic               alu_live;
   logic               md_push;
   logic               md_pop;

   logic               reg_write_q;
   logic [ADDR_W-1:0]  reg_addr_q;
   logic [DATA_W-1:0]  reg_data_q;
   logic               md_inflight_q;
   logic [NREGS-1:0]   busy_q;
   logic [NREGS-1:0]   busy_d;

   assign alu_live = ALU_VALID && (ALU_ADDR != '0);
   // Ready looks only at the registered count: a pop in the same cycle does
   // not open a slot, which keeps MD_READY free of any path from ALU_VALID.
   assign MD_READY = !RESET && (md_count < FULL_CNT);
   // Results for x0 complete the handshake but are never stored.
   assign md_push  = MD_VALID && MD_READY && (MD_ADDR != '0);
   assign md_pop   = !alu_live && (md_count != '0);
   assign md_req   = '{addr: MD_ADDR, data: MD_DATA};

   wb_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (md_push),
      .pop_i   (md_pop),
      .wdata_i (md_req),
      .rdata_o (md_head),
      .count_o (md_count)
   );

   // A new issue to the register being retired must stay busy, so the set
   // is applied after the clear.
   always_comb begin
      busy_d = busy_q;
      if (md_pop) begin
         busy_d[md_head.addr] = 1'b0;
      end
      if (ISSUE_MD && (ISSUE_ADDR != '0)) begin
         busy_d[ISSUE_ADDR] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         reg_write_q   <= 1'b0;
         reg_addr_q    <= '0;
         reg_data_q    <= '0;
         md_inflight_q <= 1'b0;
         busy_q        <= '0;
      end else begin
         busy_q <= busy_d;
         if (alu_live) begin
            reg_write_q   <= 1'b1;
            reg_addr_q    <= ALU_ADDR;
            reg_data_q    <= ALU_DATA;
            md_inflight_q <= 1'b0;
         end else if (md_pop) begin
            reg_write_q   <= 1'b1;
            reg_addr_q    <= md_head.addr;
            reg_data_q    <= md_head.data;
            md_inflight_q <= 1'b1;
         end else begin
            reg_write_q   <= 1'b0;
         end
      end
   end

   // The scoreboard bit is already clear while the popped result is on its
   // way into the register file, so the in-flight write is also matched.
   assign BUSY1 = (CHK_ADDR1 != '0) &&
                  (busy_q[CHK_ADDR1] ||
                   (reg_write_q && md_inflight_q && (reg_addr_q == CHK_ADDR1)));
   assign BUSY2 = (CHK_ADDR2 != '0) &&
                  (busy_q[CHK_ADDR2] ||
                   (reg_write_q && md_inflight_q && (reg_addr_q == CHK_ADDR2)));

   assign REG_WRITE = reg_write_q;
   assign REG_ADDR  = reg_addr_q;
   assign REG_DATA  = reg_data_q;

endmodule
